// File: rtl/down_timer_pkg.sv
// down_timer_pkg -- shared definitions for the down_timer block.
// Contents: state_e, the timer FSM state encoding (IDLE, RUN, DONE).
package down_timer_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

endpackage

// File: rtl/sat_sub.sv
// sat_sub -- combinational saturating subtractor.
// Ports:
//   a : minuend
//   b : subtrahend
//   y : a - b when a > b, otherwise 0 (never wraps below zero)
module sat_sub #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   always_comb begin
      y = (a > b) ? (a - b) : '0;
   end

endmodule

// File: rtl/down_timer.sv
// down_timer -- loadable down-counter with saturating step and one-cycle expiry pulse.
// Ports:
//   clk         : clock, all state updates on the rising edge
//   rst         : synchronous active-high reset
//   start       : load load_val and begin counting (accepted in IDLE or DONE only)
//   load_val    : start value, latched for auto-reload
//   decr        : step subtracted on each enabled RUN cycle
//   en          : count enable while in RUN
//   abort       : return to IDLE with count cleared; wins over start
//   auto_reload : only present when DOWN_TIMER_AUTO_RELOAD_EN is defined
//   count       : current timer value
//   busy        : high while in RUN
//   done        : registered one-cycle expiry pulse
// Build option: define DOWN_TIMER_AUTO_RELOAD_EN to add auto_reload; otherwise the
// timer behaves as if auto_reload were tied low.
module down_timer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] decr,
   input  logic             en,
   input  logic             abort,
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
   input  logic             auto_reload,
`endif
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done
);

   import down_timer_pkg::*;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] dec_y;
   logic             ar;

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
   assign ar = auto_reload;
`else
   assign ar = 1'b0;
`endif

   sat_sub #(
      .WIDTH(WIDTH)
   ) u_sat_sub (
      .a(count_q),
      .b(decr),
      .y(dec_y)
   );

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      done_d   = 1'b0;
      if (abort) begin
         state_d = StIdle;
         count_d = '0;
      end else begin
         case (state_q)
            StIdle, StDone: begin
               if (start) begin
                  if (load_val != '0) begin
                     count_d  = load_val;
                     reload_d = load_val;
                     state_d  = StRun;
                  end else begin
                     count_d = '0;
                     state_d = StDone;
                     done_d  = 1'b1;
                  end
               end else if (state_q == StDone) begin
                  state_d = StIdle;
               end
            end
            StRun: begin
               // Zero count while in RUN only happens right after an auto-reload
               // expiry: the zero is shown for one cycle, then the latched value returns.
               if (count_q == '0) begin
                  count_d = reload_q;
               end else if (en) begin
                  count_d = dec_y;
                  if (dec_y == '0) begin
                     done_d = 1'b1;
                     if (!ar) begin
                        state_d = StDone;
                     end
                  end
               end
            end
            default: begin
               state_d = StIdle;
               count_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         count_q  <= '0;
         reload_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         done_q   <= done_d;
      end
   end

   assign count = count_q;
   assign busy  = (state_q == StRun);
   assign done  = done_q;

endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer -- self-checking bench for down_timer: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a behavioural model.
// Define DOWN_TIMER_AUTO_RELOAD_EN to also exercise auto_reload.
module tb_down_timer;

   localparam int WIDTH = 8;
   localparam int PIdle = 0;
   localparam int PRun  = 1;
   localparam int PDone = 2;

   logic             clk      = 1'b0;
   logic             rst      = 1'b1;
   logic             start    = 1'b0;
   logic             en       = 1'b0;
   logic             abort    = 1'b0;
   logic [WIDTH-1:0] load_val = '0;
   logic [WIDTH-1:0] decr     = '0;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             done;
   logic             ar_m;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
   logic             auto_reload = 1'b0;
   assign ar_m = auto_reload;
`else
   assign ar_m = 1'b0;
`endif

   int checks   = 0;
   int failures = 0;
   bit check_en = 1'b0;

   // Behavioural model state
   int m_phase  = PIdle;
   int m_count  = 0;
   int m_reload = 0;
   bit m_done   = 1'b0;

   always #5 clk = ~clk;

   down_timer #(
      .WIDTH(WIDTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .load_val(load_val),
      .decr(decr),
      .en(en),
      .abort(abort),
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
      .auto_reload(auto_reload),
`endif
      .count(count),
      .busy(busy),
      .done(done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk3(input string name, input int c, input int b, input int d);
      check({name, "_count"}, 32'(count), c);
      check({name, "_busy"}, 32'(busy), b);
      check({name, "_done"}, 32'(done), d);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Model: timer rules expressed directly on integers.
   always @(posedge clk) begin
      if (rst) begin
         m_phase <= PIdle; m_count <= 0; m_reload <= 0; m_done <= 1'b0;
      end else if (abort) begin
         m_phase <= PIdle; m_count <= 0; m_done <= 1'b0;
      end else if (m_phase != PRun && start) begin
         if (int'(load_val) != 0) begin
            m_phase <= PRun; m_count <= int'(load_val); m_reload <= int'(load_val);
            m_done <= 1'b0;
         end else begin
            m_phase <= PDone; m_count <= 0; m_done <= 1'b1;
         end
      end else if (m_phase == PDone) begin
         m_phase <= PIdle; m_done <= 1'b0;
      end else if (m_phase == PRun && m_count == 0) begin
         m_count <= m_reload; m_done <= 1'b0;
      end else if (m_phase == PRun && en) begin
         if (m_count > int'(decr)) begin
            m_count <= m_count - int'(decr); m_done <= 1'b0;
         end else begin
            m_count <= 0; m_done <= 1'b1;
            m_phase <= ar_m ? PRun : PDone;
         end
      end else begin
         m_done <= 1'b0;
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         check("model_count", 32'(count), m_count);
         check("model_busy", 32'(busy), (m_phase == PRun) ? 1 : 0);
         check("model_done", 32'(done), 32'(m_done));
      end
   end

   initial begin
      int n_done;
      int first;
      repeat (2) tick();
      rst = 1'b0;
      check_en = 1'b1;
      chk3("reset", 0, 0, 0);

      // 10 - 3 per cycle
      start = 1'b1; load_val = 8'd10; decr = 8'd3; en = 1'b1;
      tick(); start = 1'b0;
      chk3("seq10_a", 10, 1, 0);
      tick(); chk3("seq10_b", 7, 1, 0);
      tick(); chk3("seq10_c", 4, 1, 0);
      tick(); chk3("seq10_d", 1, 1, 0);
      tick(); chk3("seq10_e", 0, 0, 1);
      tick(); chk3("seq10_idle", 0, 0, 0);

      // enable toggling
      start = 1'b1; load_val = 8'd5; decr = 8'd1; en = 1'b1;
      tick(); start = 1'b0;
      chk3("tog_load", 5, 1, 0);
      n_done = 0; first = -1;
      for (int k = 1; k <= 14; k++) begin
         en = (k % 2 == 1);
         tick();
         if (done === 1'b1) begin
            n_done++;
            if (first < 0) first = k;
         end
      end
      en = 1'b1;
      check("tog_done_count", n_done, 1);
      check("tog_done_delay", first, 9);

      // zero load
      start = 1'b1; load_val = 8'd0;
      tick(); start = 1'b0;
      chk3("zero_load", 0, 0, 1);
      tick(); chk3("zero_idle", 0, 0, 0);

      // abort + start together in RUN
      start = 1'b1; load_val = 8'd12; decr = 8'd2; en = 1'b1;
      tick(); start = 1'b0;
      tick(); tick(); tick();
      check("abort_pre", 32'(count), 6);
      abort = 1'b1; start = 1'b1; load_val = 8'd9;
      tick(); abort = 1'b0; start = 1'b0;
      chk3("abort_post", 0, 0, 0);
      tick(); chk3("abort_idle", 0, 0, 0);

      // reset during RUN
      start = 1'b1; load_val = 8'd10;
      tick(); start = 1'b0;
      tick(); tick(); tick();
      check("rst_pre", 32'(count), 4);
      rst = 1'b1;
      tick(); rst = 1'b0;
      chk3("rst_post", 0, 0, 0);

      // decr = 0 holds; start in RUN ignored
      start = 1'b1; load_val = 8'd50; decr = 8'd0; en = 1'b1;
      tick(); start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         start = (i == 10);
         load_val = 8'd7;
         tick();
      end
      start = 1'b0;
      chk3("hold_decr0", 50, 1, 0);
      abort = 1'b1;
      tick(); abort = 1'b0;
      chk3("hold_abort", 0, 0, 0);

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
      auto_reload = 1'b1;
      start = 1'b1; load_val = 8'd3; decr = 8'd1; en = 1'b1;
      tick(); start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk3("autoreload", 3 - (i % 4), 1, ((i % 4) == 3) ? 1 : 0);
         tick();
      end
      auto_reload = 1'b0;
      abort = 1'b1;
      tick(); abort = 1'b0;
`endif

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         rst      = ($urandom % 200) == 0;
         abort    = ($urandom % 40) == 0;
         start    = ($urandom % 6) == 0;
         load_val = (($urandom % 4) == 0) ? 8'd0 : 8'($urandom_range(1, 40));
         decr     = (($urandom % 16) == 0) ? 8'($urandom) : 8'($urandom_range(0, 5));
         en       = ($urandom % 4) != 0;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
         auto_reload = ($urandom % 3) == 0;
`endif
         tick();
      end
      rst = 1'b0; abort = 1'b0; start = 1'b0; en = 1'b0;
      tick();
      check_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
